// File: rtl/datapath_sequencer.sv
// ---------------------------------------------------------------------------
// datapath_sequencer
//
// Microprogram sequencer for the 4-register datapath. A small writable
// program memory is stepped through after a start request. Each RUN cycle
// executes one instruction. Outputs are registered, so the instruction at pc
// in cycle n appears on ControlWord/ConstantIn in cycle n+1.
//
// Instruction word [18:0]:
//   op = [18:17]  00 EXEC, 01 LOOP, 10 DJNZ, 11 HALT
//   cw = [16:4]   control word; for DJNZ, bits [4+AW-1:4] hold the target
//   k  = [3:0]    constant for EXEC, loop count for LOOP
//
// Ports:
//   CLK         in   rising-edge clock shared with the datapath
//   RSTn        in   asynchronous active-low reset
//   start       in   one-cycle request to run the program from address 0
//   abort       in   stop execution immediately (highest priority)
//   prog_we     in   program memory write enable (honoured only in IDLE)
//   prog_addr   in   program memory write address
//   prog_wdata  in   instruction word to write
//   ControlWord out  datapath control word (registered)
//   ConstantIn  out  datapath constant (registered)
//   busy        out  high while in RUN
//   done        out  one-cycle pulse in the cycle after HALT
//   pc          out  current program counter (debug)
// ---------------------------------------------------------------------------
module datapath_sequencer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          start,
    input  logic          abort,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [18:0]   prog_wdata,
    output logic [12:0]   ControlWord,
    output logic [3:0]    ConstantIn,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] pc
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_EXEC = 2'b00;
    localparam logic [1:0] OP_LOOP = 2'b01;
    localparam logic [1:0] OP_DJNZ = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    state_t        r_state;
    logic [18:0]   r_mem [DEPTH];
    logic [AW-1:0] r_pc;
    logic [3:0]    r_lc;
    logic [12:0]   r_cw;
    logic [3:0]    r_k;

    logic [18:0]   w_instr;
    logic [1:0]    w_op;
    logic [12:0]   w_cw;
    logic [3:0]    w_k;
    logic [AW-1:0] w_target;
    logic [AW-1:0] w_pc_inc;

    // Combinational fetch at the current pc.
    assign w_instr  = r_mem[r_pc];
    assign w_op     = w_instr[18:17];
    assign w_cw     = w_instr[16:4];
    assign w_k      = w_instr[3:0];
    assign w_target = w_instr[4+AW-1:4];
    // Natural AW-bit wrap from DEPTH-1 back to 0.
    assign w_pc_inc = r_pc + AW'(1);

    // Program memory is deliberately not reset so a program survives RSTn.
    // Writes are locked out while a program is executing.
    always_ff @(posedge CLK) begin
        if (prog_we && (r_state == S_IDLE)) begin
            r_mem[prog_addr] <= prog_wdata;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_lc    <= '0;
            r_cw    <= '0;
            r_k     <= '0;
        end else begin
            // Outputs default to zero so nothing but an EXEC in RUN can
            // cause a datapath register write.
            r_cw <= '0;
            r_k  <= '0;
            if (abort) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_state <= S_RUN;
                            r_pc    <= '0;
                        end
                    end
                    S_RUN: begin
                        case (w_op)
                            OP_EXEC: begin
                                r_cw <= w_cw;
                                r_k  <= w_k;
                                r_pc <= w_pc_inc;
                            end
                            OP_LOOP: begin
                                r_lc <= w_k;
                                r_pc <= w_pc_inc;
                            end
                            OP_DJNZ: begin
                                // lc == 0 falls through without wrapping lc.
                                if (r_lc != 4'd0) begin
                                    r_lc <= r_lc - 4'd1;
                                    r_pc <= w_target;
                                end else begin
                                    r_pc <= w_pc_inc;
                                end
                            end
                            default: begin
                                r_state <= S_DONE;
                            end
                        endcase
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign ControlWord = r_cw;
    assign ConstantIn  = r_k;
    assign busy        = (r_state == S_RUN);
    assign done        = (r_state == S_DONE);
    assign pc          = r_pc;

endmodule

// File: tb/tb_datapath_sequencer.sv
module tb_datapath_sequencer;

    logic        CLK;
    logic        RSTn;
    logic        start;
    logic        abort;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [18:0] prog_wdata;
    logic [12:0] ControlWord;
    logic [3:0]  ConstantIn;
    logic        busy;
    logic        done;
    logic [3:0]  pc;

    int n_vec = 0;
    int n_err = 0;

    // Expected outputs after edges E1..E8 of the loop program
    // (LOOP 2 / EXEC 0x0A41,k=5 / DJNZ 1 / HALT).
    logic [12:0] loop_cw   [8] = '{13'h0, 13'h0A41, 13'h0, 13'h0A41, 13'h0, 13'h0A41, 13'h0, 13'h0};
    logic [3:0]  loop_k    [8] = '{4'h0, 4'h5, 4'h0, 4'h5, 4'h0, 4'h5, 4'h0, 4'h0};
    logic        loop_done [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        loop_busy [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    datapath_sequencer #(.DEPTH(16), .AW(4)) dut (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .start       (start),
        .abort       (abort),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_wdata  (prog_wdata),
        .ControlWord (ControlWord),
        .ConstantIn  (ConstantIn),
        .busy        (busy),
        .done        (done),
        .pc          (pc)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [18:0] mk_exec(input logic [12:0] cw, input logic [3:0] k);
        return {2'b00, cw, k};
    endfunction

    function automatic logic [18:0] mk_loop(input logic [3:0] k);
        return {2'b01, 13'h0, k};
    endfunction

    function automatic logic [18:0] mk_djnz(input logic [3:0] t);
        return {2'b10, 9'h0, t, 4'h0};
    endfunction

    function automatic logic [18:0] mk_halt();
        return {2'b11, 17'h0};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic write_prog(input logic [3:0] a, input logic [18:0] w);
        prog_we    = 1'b1;
        prog_addr  = a;
        prog_wdata = w;
        tick();
        prog_we    = 1'b0;
    endtask

    task automatic load_loop_prog();
        write_prog(4'd0, mk_loop(4'd2));
        write_prog(4'd1, mk_exec(13'h0A41, 4'h5));
        write_prog(4'd2, mk_djnz(4'd1));
        write_prog(4'd3, mk_halt());
    endtask

    task automatic run_loop(input string pfx);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({pfx, "_busy_e0"}, {31'h0, busy}, 32'h1);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("%s_cw_e%0d", pfx, i + 1), {19'h0, ControlWord}, {19'h0, loop_cw[i]});
            chk($sformatf("%s_k_e%0d", pfx, i + 1), {28'h0, ConstantIn}, {28'h0, loop_k[i]});
            chk($sformatf("%s_done_e%0d", pfx, i + 1), {31'h0, done}, {31'h0, loop_done[i]});
            chk($sformatf("%s_busy_e%0d", pfx, i + 1), {31'h0, busy}, {31'h0, loop_busy[i]});
        end
        tick();
        chk({pfx, "_done_end"}, {31'h0, done}, 32'h0);
        chk({pfx, "_lc_end"}, {28'h0, dut.r_lc}, 32'h0);
    endtask

    initial begin
        RSTn       = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        prog_we    = 1'b0;
        prog_addr  = 4'd0;
        prog_wdata = 19'h0;
        #1;
        chk("rst_cw", {19'h0, ControlWord}, 32'h0);
        chk("rst_k", {28'h0, ConstantIn}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_pc", {28'h0, pc}, 32'h0);
        tick();
        tick();
        RSTn = 1'b1;
        tick();

        // Single EXEC then HALT.
        write_prog(4'd0, mk_exec(13'h1801, 4'h0));
        write_prog(4'd1, mk_halt());
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_busy_e0", {31'h0, busy}, 32'h1);
        chk("t1_cw_e0", {19'h0, ControlWord}, 32'h0);
        tick();
        chk("t1_cw_e1", {19'h0, ControlWord}, 32'h1801);
        chk("t1_busy_e1", {31'h0, busy}, 32'h1);
        chk("t1_done_e1", {31'h0, done}, 32'h0);
        tick();
        chk("t1_cw_e2", {19'h0, ControlWord}, 32'h0);
        chk("t1_done_e2", {31'h0, done}, 32'h1);
        chk("t1_busy_e2", {31'h0, busy}, 32'h0);
        tick();
        chk("t1_done_e3", {31'h0, done}, 32'h0);

        // Counted loop.
        load_loop_prog();
        run_loop("t2");

        // No HALT: pc wraps and execution continues until abort.
        for (int i = 0; i < 16; i++) begin
            write_prog(4'(i), mk_exec(13'h100 + 13'(i), 4'(i)));
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            tick();
            chk($sformatf("t3_cw_e%0d", j), {19'h0, ControlWord}, 32'h100 + 32'((j - 1) % 16));
            chk($sformatf("t3_k_e%0d", j), {28'h0, ConstantIn}, 32'((j - 1) % 16));
            chk($sformatf("t3_pc_e%0d", j), {28'h0, pc}, 32'(j % 16));
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t3_abort_busy", {31'h0, busy}, 32'h0);
        chk("t3_abort_cw", {19'h0, ControlWord}, 32'h0);
        chk("t3_abort_done", {31'h0, done}, 32'h0);
        tick();
        chk("t3_abort_done2", {31'h0, done}, 32'h0);
        chk("t3_abort_busy2", {31'h0, busy}, 32'h0);

        // Program write during RUN is ignored; same write in IDLE applies.
        write_prog(4'd0, mk_exec(13'h0011, 4'h1));
        write_prog(4'd1, mk_exec(13'h0022, 4'h2));
        write_prog(4'd2, mk_exec(13'h0033, 4'h3));
        write_prog(4'd3, mk_halt());
        start = 1'b1;
        tick();
        start      = 1'b0;
        prog_we    = 1'b1;
        prog_addr  = 4'd1;
        prog_wdata = mk_halt();
        tick();
        prog_we    = 1'b0;
        chk("t4_cw_e1", {19'h0, ControlWord}, 32'h0011);
        tick();
        chk("t4_cw_e2", {19'h0, ControlWord}, 32'h0022);
        chk("t4_k_e2", {28'h0, ConstantIn}, 32'h2);
        tick();
        chk("t4_cw_e3", {19'h0, ControlWord}, 32'h0033);
        tick();
        chk("t4_cw_e4", {19'h0, ControlWord}, 32'h0);
        chk("t4_done_e4", {31'h0, done}, 32'h1);
        tick();
        write_prog(4'd1, mk_halt());
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("t4b_cw_e1", {19'h0, ControlWord}, 32'h0011);
        tick();
        chk("t4b_cw_e2", {19'h0, ControlWord}, 32'h0);
        chk("t4b_done_e2", {31'h0, done}, 32'h1);
        tick();

        // Asynchronous reset mid-loop, then rerun the retained program.
        load_loop_prog();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        tick();
        chk("t5_cw_pre", {19'h0, ControlWord}, 32'h0A41);
        chk("t5_lc_pre", {28'h0, dut.r_lc}, 32'h1);
        #2;
        RSTn = 1'b0;
        #1;
        chk("t5_rst_cw", {19'h0, ControlWord}, 32'h0);
        chk("t5_rst_k", {28'h0, ConstantIn}, 32'h0);
        chk("t5_rst_busy", {31'h0, busy}, 32'h0);
        chk("t5_rst_pc", {28'h0, pc}, 32'h0);
        chk("t5_rst_lc", {28'h0, dut.r_lc}, 32'h0);
        tick();
        RSTn = 1'b1;
        tick();
        run_loop("t5_rerun");

        // Start and abort together in IDLE.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("t6_busy_e0", {31'h0, busy}, 32'h0);
        chk("t6_cw_e0", {19'h0, ControlWord}, 32'h0);
        tick();
        chk("t6_busy_e1", {31'h0, busy}, 32'h0);
        chk("t6_done_e1", {31'h0, done}, 32'h0);
        run_loop("t6_run");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
